// File: rtl/packet_receiver.sv
// rtl/packet_receiver.sv - UART byte-stream packet framer (optional PKT_RX_CHECKSUM_EN trailing XOR byte)
module packet_receiver #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_WORDS      = 16,
    parameter int         TIMEOUT_CYCLES = 10416
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic [7:0]  word_index,
    output logic        pkt_start,
    output logic        pkt_done,
    output logic        pkt_error,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN  = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LO,
        S_HI
`ifdef PKT_RX_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   word_out_q, word_out_d;
    logic          word_valid_q, word_valid_d;
    logic [7:0]    word_index_q, word_index_d;
    logic          pkt_start_q, pkt_start_d;
    logic          pkt_done_q, pkt_done_d;
    logic          pkt_error_q, pkt_error_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          busy_q, busy_d;
    logic          tmo_hit;
`ifdef PKT_RX_CHECKSUM_EN
    logic [7:0]    acc_q, acc_d;
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        lo_d         = lo_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        word_index_d = word_index_q;
        pkt_start_d  = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_error_d  = 1'b0;
        err_code_d   = err_code_q;
`ifdef PKT_RX_CHECKSUM_EN
        acc_d        = acc_q;
`endif

        // Idle-gap counter; a byte always restarts it
        if (rx_valid || state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q != '1) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end
        tmo_hit = (state_q != S_IDLE) && !rx_valid && (tmo_q == TMO_LAST);

        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) state_d = S_LEN;
                end
                S_LEN: begin
                    if (rx_data != 8'd0 && rx_data <= MAX_LEN) begin
                        len_d       = rx_data;
                        cnt_d       = 8'd0;
                        pkt_start_d = 1'b1;
                        err_code_d  = 2'd0;
                        state_d     = S_LO;
`ifdef PKT_RX_CHECKSUM_EN
                        acc_d       = rx_data;
`endif
                    end else begin
                        pkt_done_d  = 1'b1;
                        pkt_error_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = S_IDLE;
                    end
                end
                S_LO: begin
                    lo_d    = rx_data;
                    state_d = S_HI;
`ifdef PKT_RX_CHECKSUM_EN
                    acc_d   = acc_q ^ rx_data;
`endif
                end
                S_HI: begin
                    word_out_d   = {rx_data, lo_q};
                    word_valid_d = 1'b1;
                    word_index_d = cnt_q;
                    cnt_d        = cnt_q + 8'd1;
`ifdef PKT_RX_CHECKSUM_EN
                    acc_d        = acc_q ^ rx_data;
                    state_d      = (cnt_q + 8'd1 == len_q) ? S_CSUM : S_LO;
`else
                    if (cnt_q + 8'd1 == len_q) begin
                        pkt_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d    = S_LO;
                    end
`endif
                end
`ifdef PKT_RX_CHECKSUM_EN
                S_CSUM: begin
                    pkt_done_d = 1'b1;
                    if (rx_data != acc_q) begin
                        pkt_error_d = 1'b1;
                        err_code_d  = 2'd3;
                    end
                    state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            pkt_done_d  = 1'b1;
            pkt_error_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            lo_q         <= 8'd0;
            word_out_q   <= 16'd0;
            word_valid_q <= 1'b0;
            word_index_q <= 8'd0;
            pkt_start_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_error_q  <= 1'b0;
            err_code_q   <= 2'd0;
            busy_q       <= 1'b0;
`ifdef PKT_RX_CHECKSUM_EN
            acc_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            lo_q         <= lo_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            word_index_q <= word_index_d;
            pkt_start_q  <= pkt_start_d;
            pkt_done_q   <= pkt_done_d;
            pkt_error_q  <= pkt_error_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
`ifdef PKT_RX_CHECKSUM_EN
            acc_q        <= acc_d;
`endif
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_index = word_index_q;
    assign pkt_start  = pkt_start_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_error  = pkt_error_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_packet_receiver.sv
// tb/tb_packet_receiver.sv - directed self-checking bench for packet_receiver
module tb_packet_receiver;

    logic        clk;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] word_out;
    logic        word_valid;
    logic [7:0]  word_index;
    logic        pkt_start;
    logic        pkt_done;
    logic        pkt_error;
    logic [1:0]  err_code;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // event log filled by the monitor
    int          nw = 0;
    logic [15:0] wd [0:1023];
    logic [7:0]  wi [0:1023];
    int          n_start = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          n_done_w = 0;

    int b_w, b_s, b_d, b_e, b_dw;

    logic [7:0] pq[$];

    packet_receiver #(
        .SYNC_BYTE(8'hA5),
        .MAX_WORDS(16),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .word_out(word_out),
        .word_valid(word_valid),
        .word_index(word_index),
        .pkt_start(pkt_start),
        .pkt_done(pkt_done),
        .pkt_error(pkt_error),
        .err_code(err_code),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid) begin
            wd[nw] = word_out;
            wi[nw] = word_index;
            nw = nw + 1;
        end
        if (pkt_start) n_start = n_start + 1;
        if (pkt_done) n_done = n_done + 1;
        if (pkt_error) n_err = n_err + 1;
        if (pkt_done && word_valid) n_done_w = n_done_w + 1;
    end

    task automatic mark;
        b_w = nw; b_s = n_start; b_d = n_done; b_e = n_err; b_dw = n_done_w;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // send pq with one idle cycle between bytes, no checksum byte
    task automatic send_raw;
        foreach (pq[i]) begin
            send(pq[i]);
            idle(1);
        end
    endtask

    // send pq as a complete packet; appends the XOR trailer when enabled
    task automatic send_pkt;
        logic [7:0] x;
        x = 8'h00;
        foreach (pq[i]) if (i > 0) x = x ^ pq[i];
        send_raw();
`ifdef PKT_RX_CHECKSUM_EN
        send(x);
        idle(1);
`endif
        idle(3);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if ({word_out, word_valid, word_index, pkt_start, pkt_done, pkt_error, err_code, busy} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {word_out, word_valid, word_index, pkt_start, pkt_done, pkt_error, err_code, busy});
        end
    endtask

    task automatic test_two_words;
        mark();
        pq = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56};
        send_pkt();
        chk("t1_nwords", 32'(nw - b_w), 32'd2);
        chk("t1_word0", {16'd0, wd[b_w]}, 32'h1234);
        chk("t1_idx0", {24'd0, wi[b_w]}, 32'd0);
        chk("t1_word1", {16'd0, wd[b_w + 1]}, 32'h5678);
        chk("t1_idx1", {24'd0, wi[b_w + 1]}, 32'd1);
        chk("t1_start", 32'(n_start - b_s), 32'd1);
        chk("t1_done", 32'(n_done - b_d), 32'd1);
        chk("t1_err", 32'(n_err - b_e), 32'd0);
`ifndef PKT_RX_CHECKSUM_EN
        chk("t1_done_with_word", 32'(n_done_w - b_dw), 32'd1);
`endif
        chk("t1_err_code", {30'd0, err_code}, 32'd0);
    endtask

    task automatic test_leading_garbage;
        mark();
        pq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hCD, 8'hAB};
        send_pkt();
        chk("t2_nwords", 32'(nw - b_w), 32'd1);
        chk("t2_word", {16'd0, wd[b_w]}, 32'hABCD);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_done", 32'(n_done - b_d), 32'd1);
    endtask

    task automatic test_bad_length;
        mark();
        pq = '{8'hA5, 8'h00};
        send_raw(); idle(2);
        chk("t3_len0_err_code", {30'd0, err_code}, 32'd1);
        chk("t3_len0_err", 32'(n_err - b_e), 32'd1);
        pq = '{8'hA5, 8'h11};
        send_raw(); idle(2);
        chk("t3_len17_err_code", {30'd0, err_code}, 32'd1);
        chk("t3_bad_done", 32'(n_done - b_d), 32'd2);
        chk("t3_bad_err", 32'(n_err - b_e), 32'd2);
        chk("t3_bad_nowords", 32'(nw - b_w), 32'd0);
        chk("t3_bad_nostart", 32'(n_start - b_s), 32'd0);
        mark();
        pq = '{8'hA5, 8'h01, 8'hEF, 8'hBE};
        send_pkt();
        chk("t3_after_word", {16'd0, wd[b_w]}, 32'hBEEF);
        chk("t3_after_err_code", {30'd0, err_code}, 32'd0);
        chk("t3_after_err", 32'(n_err - b_e), 32'd0);
    endtask

    task automatic test_max_len;
        mark();
        pq = '{8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) begin
            pq.push_back(8'(i));
            pq.push_back(8'(8'hF0 | i));
        end
        send_pkt();
        chk("max_nwords", 32'(nw - b_w), 32'd16);
        chk("max_last_word", {16'd0, wd[b_w + 15]}, 32'hFF0F);
        chk("max_last_idx", {24'd0, wi[b_w + 15]}, 32'd15);
        chk("max_err", 32'(n_err - b_e), 32'd0);
    endtask

    task automatic test_timeout;
        mark();
        pq = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78};
        send_raw();
        idle(40);
        chk("t4_nwords", 32'(nw - b_w), 32'd1);
        chk("t4_word", {16'd0, wd[b_w]}, 32'h1234);
        chk("t4_err", 32'(n_err - b_e), 32'd1);
        chk("t4_err_code", {30'd0, err_code}, 32'd2);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        mark();
        pq = '{8'hA5, 8'h01, 8'h22, 8'h11};
        send_pkt();
        chk("t4_after_word", {16'd0, wd[b_w]}, 32'h1122);
        chk("t4_after_err", 32'(n_err - b_e), 32'd0);
    endtask

    // longest legal gap (TIMEOUT_CYCLES-1 idle cycles) must not time out
    task automatic test_gap_boundary;
        mark();
        send(8'hA5); idle(1);
        send(8'h01); idle(1);
        send(8'hCD); idle(31);
        send(8'hAB); idle(1);
`ifdef PKT_RX_CHECKSUM_EN
        send(8'h01 ^ 8'hCD ^ 8'hAB); idle(1);
`endif
        idle(3);
        chk("gap_nwords", 32'(nw - b_w), 32'd1);
        chk("gap_word", {16'd0, wd[b_w]}, 32'hABCD);
        chk("gap_err", 32'(n_err - b_e), 32'd0);
    endtask

    // sync accepted on the cycle right after done; sync value as payload
    task automatic test_back_to_back;
        mark();
        send(8'hA5); send(8'h01); send(8'hA5); send(8'hA5);
`ifdef PKT_RX_CHECKSUM_EN
        send(8'h01);
`endif
        send(8'hA5); send(8'h01); send(8'h3C); send(8'h5A);
`ifdef PKT_RX_CHECKSUM_EN
        send(8'h01 ^ 8'h3C ^ 8'h5A);
`endif
        idle(4);
        chk("b2b_nwords", 32'(nw - b_w), 32'd2);
        chk("b2b_word0", {16'd0, wd[b_w]}, 32'hA5A5);
        chk("b2b_word1", {16'd0, wd[b_w + 1]}, 32'h5A3C);
        chk("b2b_start", 32'(n_start - b_s), 32'd2);
        chk("b2b_err", 32'(n_err - b_e), 32'd0);
    endtask

    task automatic test_reset_mid_packet;
        mark();
        pq = '{8'hA5, 8'h03, 8'h11};
        send_raw();
        chk("t5_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        test_reset();
        chk("t5_busy_in_reset", {31'd0, busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        mark();
        pq = '{8'hA5, 8'h01, 8'h22, 8'h33};
        send_pkt();
        chk("t5_nwords", 32'(nw - b_w), 32'd1);
        chk("t5_word", {16'd0, wd[b_w]}, 32'h3322);
        chk("t5_idx", {24'd0, wi[b_w]}, 32'd0);
    endtask

`ifdef PKT_RX_CHECKSUM_EN
    task automatic test_checksum;
        mark();
        pq = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h27};
        send_raw(); idle(3);
        chk("t6_good_word", {16'd0, wd[b_w]}, 32'h1234);
        chk("t6_good_done", 32'(n_done - b_d), 32'd1);
        chk("t6_good_err", 32'(n_err - b_e), 32'd0);
        mark();
        pq = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h26};
        send_raw(); idle(3);
        chk("t6_bad_err", 32'(n_err - b_e), 32'd1);
        chk("t6_bad_err_code", {30'd0, err_code}, 32'd3);
    endtask
`endif

    initial begin
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_two_words();
        test_leading_garbage();
        test_bad_length();
        test_max_len();
        test_timeout();
        test_gap_boundary();
        test_back_to_back();
        test_reset_mid_packet();
`ifdef PKT_RX_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/packet_receiver.md
Name: packet_receiver

Overview:
Host-to-FPGA receive stage for the UART offload link.
- Consumes the byte strobe from the 8N1 UART receiver and frames packets of the form SYNC, LEN, then LEN 16-bit words sent LSB byte first.
- Streams each reassembled word to the compute core.
- Mirrors the outbound word sender, which serialises 16-bit results LSB first.
- Adds resynchronisation via an inter-byte timeout and length checking.

Parameters:
SYNC_BYTE, 8'hA5, start-of-packet marker
MAX_WORDS, 16, largest legal LEN value (1..255)
TIMEOUT_CYCLES, 10416, idle clocks allowed between bytes inside a packet (about 10 byte times at 12 MHz / 115200)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_data  in  8  received byte from the UART RX
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
word_out  out  16  assembled word {hi, lo}
word_valid  out  1  one-cycle pulse; word_out is valid
word_index  out  8  index of word_out within the packet (0-based)
pkt_start  out  1  one-cycle pulse when a legal LEN is accepted
pkt_done  out  1  one-cycle pulse when the packet ends (good or bad)
pkt_error  out  1  one-cycle pulse with pkt_done on a failed packet
err_code  out  2  0 none, 1 bad length, 2 timeout, 3 checksum; held until the next pkt_start
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE; all outputs 0; word_out=0; timeout counter=0; byte counters=0.
- Every output is registered. Response appears the cycle after the rx_valid that causes it.
- States: IDLE, LEN, LO, HI, CSUM (CSUM exists only with the optional feature).
- IDLE:
  - rx_valid && rx_data==SYNC_BYTE -> LEN.
  - All other bytes are silently dropped.
- LEN:
  - Byte in 1..MAX_WORDS -> latch it as len, clear word count, pulse pkt_start, set err_code=0, go to LO.
  - Byte 0 or >MAX_WORDS -> pulse pkt_done + pkt_error, set err_code=1, go to IDLE.
- LO: latch the byte as the low half, go to HI.
- HI:
  - word_out={byte, lo}; pulse word_valid; word_index=current count; increment count.
  - If count+1==len: without the feature, pulse pkt_done in the same cycle as the last word_valid and go to IDLE; with the feature, go to CSUM.
  - Otherwise go to LO.
- Timeout counter:
  - Cleared on every rx_valid and while in IDLE.
  - Otherwise increments, saturating.
  - Reaching TIMEOUT_CYCLES-1 in a non-IDLE state -> pulse pkt_done + pkt_error, set err_code=2, go to IDLE.
  - Words already emitted are not retracted.
- rx_valid and timeout expiry in the same cycle: the byte wins and the counter clears.
- A SYNC_BYTE value inside LEN/LO/HI is treated as data, not a restart.
- No backpressure. The consumer must accept word_valid every pulse; the minimum spacing is 2 byte times.
- Back-to-back packets: a SYNC arriving on the cycle after return to IDLE must be accepted.

Optional Feature:
PKT_RX_CHECKSUM_EN
- Defined:
  - The packet carries a trailing byte equal to the XOR of LEN and all payload bytes.
  - A running XOR accumulates from the LEN byte onward.
  - In CSUM, on rx_valid: pulse pkt_done. If the received byte != accumulator, also pulse pkt_error and set err_code=3.
  - Go to IDLE. CSUM is subject to the timeout.
- Undefined: no CSUM state and no accumulator; err_code value 3 never occurs.

Test Plan:
1. After reset, send A5 02 34 12 78 56 → word_valid twice: 16'h1234 at index 0, 16'h5678 at index 1. pkt_start once; pkt_done with the second word; pkt_error=0.
2. Send 00 FF A5 01 CD AB → leading bytes ignored; one word 16'hABCD; busy low after done.
3. Send A5 00, then A5 11 with MAX_WORDS=16 → both give pkt_done+pkt_error with err_code=1 and no word_valid. A following A5 01 EF BE is then received correctly.
4. Send A5 02 34 12 78, then silence ≥TIMEOUT_CYCLES → one word 16'h1234, then pkt_error with err_code=2. A following good packet decodes correctly.
5. Assert resetn=0 mid-payload (after A5 03 11) → all outputs 0 and state IDLE immediately. The next A5 01 22 33 yields 16'h3322.
6. With PKT_RX_CHECKSUM_EN, send A5 01 34 12 then 27 → word 16'h1234 and pkt_done with pkt_error=0. Sending 26 instead → pkt_error, err_code=3.
